// File: rtl/character_motion_sequencer.sv
// Per-frame movement engine: walks characters 0..4, reads (x, y), steps one move in the
// snapshotted direction, clamps to the maze bounds and writes the result back.
module character_motion_sequencer #(
    parameter int unsigned STEP  = 1,
    parameter int unsigned MIN_X = 2,
    parameter int unsigned MAX_X = 157,
    parameter int unsigned MIN_Y = 2,
    parameter int unsigned MAX_Y = 117
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       start_i,
    input  logic [4:0] move_en_i,
    input  logic [9:0] dir_i,
    input  logic [7:0] x_out_i,
    input  logic [7:0] y_out_i,
    output logic [2:0] character_type_o,
    output logic       readwrite_o,
    output logic [7:0] x_in_o,
    output logic [7:0] y_in_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {StIdle, StReq, StCap, StWr, StDone} state_e;

    localparam logic [2:0]        LastIdx = 3'd4;
    localparam logic signed [9:0] StepS   = 10'(STEP);
    localparam logic signed [9:0] MinXS   = 10'(MIN_X);
    localparam logic signed [9:0] MaxXS   = 10'(MAX_X);
    localparam logic signed [9:0] MinYS   = 10'(MIN_Y);
    localparam logic signed [9:0] MaxYS   = 10'(MAX_Y);

    state_e     state_q;
    logic [2:0] index_q;
    logic [4:0] move_en_q;
    logic [9:0] dir_q;
    logic [2:0] ctype_q;
    logic       rw_q;
    logic [7:0] x_in_q;
    logic [7:0] y_in_q;
    logic       busy_q;
    logic       done_q;

    logic [1:0]        cur_dir;
    logic signed [9:0] x_s;
    logic signed [9:0] y_s;
    logic [7:0]        x_new_d;
    logic [7:0]        y_new_d;

    function automatic logic [7:0] clamp(input logic signed [9:0] v,
                                         input logic signed [9:0] lo,
                                         input logic signed [9:0] hi);
        logic signed [9:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r[7:0];
    endfunction

    // Both axes are always clamped so out-of-range positions are repaired even when disabled.
    always_comb begin
        cur_dir = dir_q[{index_q, 1'b0} +: 2];
        x_s     = $signed({2'b00, x_out_i});
        y_s     = $signed({2'b00, y_out_i});
        if (move_en_q[index_q]) begin
            case (cur_dir)
                2'b00:   y_s = y_s - StepS;
                2'b01:   y_s = y_s + StepS;
                2'b10:   x_s = x_s - StepS;
                default: x_s = x_s + StepS;
            endcase
        end
        x_new_d = clamp(x_s, MinXS, MaxXS);
        y_new_d = clamp(y_s, MinYS, MaxYS);
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q   <= StIdle;
            index_q   <= '0;
            move_en_q <= '0;
            dir_q     <= '0;
            ctype_q   <= '0;
            rw_q      <= 1'b0;
            x_in_q    <= '0;
            y_in_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rw_q    <= 1'b0;
                    ctype_q <= '0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        move_en_q <= move_en_i;
                        dir_q     <= dir_i;
                        index_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    state_q <= StCap;
                end
                StCap: begin
                    rw_q    <= 1'b1;
                    x_in_q  <= x_new_d;
                    y_in_q  <= y_new_d;
                    state_q <= StWr;
                end
                StWr: begin
                    rw_q <= 1'b0;
                    if (index_q == LastIdx) begin
                        ctype_q <= '0;
                        index_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        index_q <= index_q + 3'd1;
                        ctype_q <= index_q + 3'd1;
                        state_q <= StReq;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    rw_q    <= 1'b0;
                    ctype_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign character_type_o = ctype_q;
    assign readwrite_o      = rw_q;
    assign x_in_o           = x_in_q;
    assign y_in_o           = y_in_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_character_motion_sequencer.sv
// Bench for character_motion_sequencer: two instances (STEP 1 and 4) each with a register-file
// model; predicted writes are queued per instance and compared as write strobes appear.
module tb_character_motion_sequencer;

    logic       clock_50;
    logic       reset;
    logic       start;
    logic [4:0] move_en;
    logic [9:0] dir;

    logic [7:0] x_out [2];
    logic [7:0] y_out [2];
    logic [2:0] ctype [2];
    logic       rw    [2];
    logic [7:0] x_in  [2];
    logic [7:0] y_in  [2];
    logic       busy  [2];
    logic       done  [2];

    logic [7:0] mem_x [2][5];
    logic [7:0] mem_y [2][5];
    int         pos_x [2][5];
    int         pos_y [2][5];

    typedef struct {
        int ct;
        int x;
        int y;
    } exp_t;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_checks = 0;
    int n_errors = 0;

    localparam int Steps[2] = '{1, 4};
    localparam int InitPos[5] = '{2, 20, 40, 60, 80};

    character_motion_sequencer #(.STEP(1)) u_dut (
        .clock_50        (clock_50),
        .reset           (reset),
        .start_i         (start),
        .move_en_i       (move_en),
        .dir_i           (dir),
        .x_out_i         (x_out[0]),
        .y_out_i         (y_out[0]),
        .character_type_o(ctype[0]),
        .readwrite_o     (rw[0]),
        .x_in_o          (x_in[0]),
        .y_in_o          (y_in[0]),
        .busy_o          (busy[0]),
        .done_o          (done[0])
    );

    character_motion_sequencer #(.STEP(4)) u_dut_s4 (
        .clock_50        (clock_50),
        .reset           (reset),
        .start_i         (start),
        .move_en_i       (move_en),
        .dir_i           (dir),
        .x_out_i         (x_out[1]),
        .y_out_i         (y_out[1]),
        .character_type_o(ctype[1]),
        .readwrite_o     (rw[1]),
        .x_in_o          (x_in[1]),
        .y_in_o          (y_in[1]),
        .busy_o          (busy[1]),
        .done_o          (done[1])
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Register file models: synchronous read, write on readwrite strobe.
    always @(posedge clock_50) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 5; i++) begin
                    mem_x[k][i] <= 8'(InitPos[i]);
                    mem_y[k][i] <= 8'(InitPos[i]);
                end
                x_out[k] <= '0;
                y_out[k] <= '0;
            end else if (ctype[k] < 3'd5) begin
                if (rw[k]) begin
                    mem_x[k][ctype[k]] <= x_in[k];
                    mem_y[k][ctype[k]] <= y_in[k];
                end
                x_out[k] <= mem_x[k][ctype[k]];
                y_out[k] <= mem_y[k][ctype[k]];
            end
        end
    end

    always @(negedge clock_50) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (rw[k] === 1'b1) begin
                    exp_t e;
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        check($sformatf("unexpected_write%0d", k), 32'(ctype[k]), 32'hffff);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("wr_ct%0d", k), 32'(ctype[k]), 32'(e.ct));
                        check($sformatf("wr_x%0d_c%0d", k, e.ct), 32'(x_in[k]), 32'(e.x));
                        check($sformatf("wr_y%0d_c%0d", k, e.ct), 32'(y_in[k]), 32'(e.y));
                    end
                end
            end
        end
    end

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                pos_x[k][i] = InitPos[i];
                pos_y[k][i] = InitPos[i];
            end
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic predict(input logic [4:0] en, input logic [9:0] d);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                exp_t e;
                logic [1:0] di;
                int nx = pos_x[k][i];
                int ny = pos_y[k][i];
                di = d[2*i +: 2];
                if (en[i]) begin
                    case (di)
                        2'b00: ny = ny - Steps[k];
                        2'b01: ny = ny + Steps[k];
                        2'b10: nx = nx - Steps[k];
                        default: nx = nx + Steps[k];
                    endcase
                end
                nx = clampi(nx, 2, 157);
                ny = clampi(ny, 2, 117);
                pos_x[k][i] = nx;
                pos_y[k][i] = ny;
                e = '{ct: i, x: nx, y: ny};
                if (k == 0) exp_q0.push_back(e);
                else exp_q1.push_back(e);
            end
        end
    endtask

    task automatic preload(input int i, input int x, input int y);
        for (int k = 0; k < 2; k++) begin
            mem_x[k][i] = 8'(x);
            mem_y[k][i] = 8'(y);
            pos_x[k][i] = x;
            pos_y[k][i] = y;
        end
    endtask

    task automatic do_reset();
        @(negedge clock_50);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock_50);
        check("rst_ct", 32'(ctype[0]), 0);
        check("rst_rw", 32'(rw[0]), 0);
        check("rst_xy", 32'({x_in[0], y_in[0]}), 0);
        check("rst_busy_done", 32'({busy[0], done[0]}), 0);
        @(negedge clock_50);
        reset = 1'b0;
        reset_model();
    endtask

    task automatic run_pass(input logic [4:0] en, input logic [9:0] d, input bit toggle,
                            input bit extra_start, input int reset_at, input string name);
        int first_done = 0;
        int n_done = 0;
        int n_busy = 0;
        @(negedge clock_50);
        predict(en, d);
        start   = 1'b1;
        move_en = en;
        dir     = d;
        @(posedge clock_50);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clock_50);
            if (reset_at != 0 && cyc == reset_at + 1) begin
                check({name, "_rw_after_rst"}, 32'({rw[0], rw[1]}), 0);
                check({name, "_busy_after_rst"}, 32'({busy[0], busy[1]}), 0);
                check({name, "_done_after_rst"}, 32'({done[0], done[1]}), 0);
                reset = 1'b0;
                reset_model();
                break;
            end
            if (busy[0]) n_busy++;
            if (done[0]) begin
                n_done++;
                if (first_done == 0) first_done = cyc;
            end
            start = (extra_start && cyc == 5);
            if (toggle && cyc == 2) begin
                dir     = '1;
                move_en = '1;
            end
            if (reset_at != 0 && cyc == reset_at) reset = 1'b1;
        end
        if (reset_at == 0) begin
            check({name, "_done_cycle"}, 32'(first_done), 16);
            check({name, "_done_pulses"}, 32'(n_done), 1);
            check({name, "_busy_cycles"}, 32'(n_busy), 15);
            check({name, "_sb_left0"}, 32'(exp_q0.size()), 0);
            check({name, "_sb_left1"}, 32'(exp_q1.size()), 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        move_en = '0;
        dir     = '0;
        reset_model();

        // Reset state and a pass with nothing enabled.
        do_reset();
        run_pass(5'b00000, 10'b0, 1'b0, 1'b0, 0, "idle_pass");
        check("idle_g4_x", 32'(mem_x[0][4]), 80);

        // Pacman moves right by one step.
        run_pass(5'b00001, 10'b00_00_00_00_11, 1'b0, 1'b0, 0, "pac_right");
        check("pac_right_x", 32'(mem_x[0][0]), 3);
        check("pac_right_y", 32'(mem_y[0][0]), 2);
        check("pac_right_x_s4", 32'(mem_x[1][0]), 6);

        // Bound saturation, plus repair of an out-of-range disabled ghost.
        do_reset();
        preload(4, 80, 117);
        preload(1, 200, 0);
        run_pass(5'b10001, 10'b01_00_00_00_10, 1'b0, 1'b0, 0, "bounds");
        check("bounds_pac_x", 32'(mem_x[0][0]), 2);
        check("bounds_g4_y", 32'(mem_y[0][4]), 117);
        check("bounds_g1_x", 32'(mem_x[0][1]), 157);
        check("bounds_g1_y", 32'(mem_y[0][1]), 2);

        // Ghost2 up; mid-pass input changes must not matter.
        run_pass(5'b00100, 10'b00_00_00_00_00, 1'b1, 1'b0, 0, "g2_up");
        check("g2_up_s4_x", 32'(mem_x[1][2]), 40);
        check("g2_up_s4_y", 32'(mem_y[1][2]), 36);
        check("g2_up_s1_y", 32'(mem_y[0][2]), 39);

        // Second start during the pass is dropped.
        run_pass(5'b11111, 10'b11_10_01_00_11, 1'b0, 1'b1, 0, "restart");

        // Reset mid-pass, then a clean pass from reset positions.
        run_pass(5'b11111, 10'b11_11_11_11_11, 1'b0, 1'b0, 8, "midrst");
        run_pass(5'b11111, 10'b11_11_11_11_11, 1'b0, 1'b0, 0, "after_rst");
        check("after_rst_g3_x", 32'(mem_x[0][3]), 61);

        for (int r = 0; r < 3; r++) begin
            run_pass(5'($urandom), 10'($urandom), 1'b0, 1'b0, 0, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
